// File: rtl/adc_ddr_writer_if.sv
// Memory write-port bundle between adc_ddr_writer (master) and a memory controller (slave).
// A transfer happens on any cycle where Wr_Req and Wr_Ack are both high.
interface adc_ddr_writer_if #(
  parameter int ADDR_W = 32
);
  logic              Wr_Req;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [31:0]       Wr_Data;
  logic              Wr_Ack;

  modport master (output Wr_Req, Wr_Addr, Wr_Data, input Wr_Ack);
  modport slave  (input Wr_Req, Wr_Addr, Wr_Data, output Wr_Ack);
endinterface

// File: rtl/adc_ddr_writer.sv
// Packs 16-bit ADC samples into 32-bit words, buffers them and streams them to a memory write port.
// Optional macro ACQ_HEADER_EN prepends a {16'hA5A5, length} header word to every capture.
module adc_ddr_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [15:0]       ADC_Data,
  input  logic              ADC_Conv_Done,
  input  logic              DDR_WR_Start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [15:0]       Acq_Length,
  adc_ddr_writer_if.master  wr,
  output logic              Busy,
  output logic              Acq_Done,
  output logic              Overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

`ifdef ACQ_HEADER_EN
  // A zero-length capture still has its header word to write out.
  localparam state_t ZERO_LEN_STATE = S_DRAIN;
`else
  localparam state_t ZERO_LEN_STATE = S_DONE;
`endif

  state_t            state, state_nxt;

  // Capture bookkeeping
  logic [15:0]       remaining;
  logic              half;
  logic [15:0]       low_half;
  logic [ADDR_W-1:0] addr;

  // FSM-decoded strobes
  logic              start_acc;
  logic              take;
  logic              last_take;
  logic              push;
  logic [31:0]       push_word;

  // Word buffer
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty, full;
  logic              do_push, pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign do_push   = push & ~full;
  assign pop       = wr.Wr_Req & wr.Wr_Ack;
  assign last_take = take & (remaining == 16'd1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:    if (DDR_WR_Start) state_nxt = (Acq_Length == 16'd0) ? ZERO_LEN_STATE : S_CAPTURE;
      S_CAPTURE: if (last_take)    state_nxt = S_DRAIN;
      S_DRAIN:   if (empty)        state_nxt = S_DONE;
      S_DONE:                      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // FSM: output decode
  always_comb begin
    start_acc = 1'b0;
    take      = 1'b0;
    push      = 1'b0;
    push_word = '0;
    Busy      = 1'b0;
    Acq_Done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (DDR_WR_Start) begin
          start_acc = 1'b1;
`ifdef ACQ_HEADER_EN
          push      = 1'b1;
          push_word = {16'hA5A5, Acq_Length};
`endif
        end
      end
      S_CAPTURE: begin
        Busy = 1'b1;
        if (ADC_Conv_Done) begin
          take = 1'b1;
          if (half) begin
            push      = 1'b1;
            push_word = {ADC_Data, low_half};
          end else if (remaining == 16'd1) begin
            // Odd length: the final sample goes out alone with a zero upper half.
            push      = 1'b1;
            push_word = {16'h0000, ADC_Data};
          end
        end
      end
      S_DRAIN: Busy = 1'b1;
      S_DONE: begin
        Busy     = 1'b1;
        Acq_Done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture counters, packing register, write address and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      remaining <= '0;
      half      <= 1'b0;
      low_half  <= '0;
      addr      <= '0;
      Overflow  <= 1'b0;
    end else begin
      if (start_acc) begin
        remaining <= Acq_Length;
        half      <= 1'b0;
        addr      <= Base_Addr;
        Overflow  <= 1'b0;
      end else begin
        if (take) begin
          // Dropped words still consume their samples, so the count always advances.
          remaining <= remaining - 16'd1;
          if (!half && !last_take) begin
            half     <= 1'b1;
            low_half <= ADC_Data;
          end else begin
            half     <= 1'b0;
          end
        end
        if (pop)          addr     <= addr + ADDR_W'(4);
        if (push && full) Overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; reads are qualified by the occupancy count instead.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  assign wr.Wr_Req  = ~empty;
  assign wr.Wr_Addr = addr;
  assign wr.Wr_Data = empty ? 32'h0 : mem[rd_ptr];

endmodule

// File: tb/tb_adc_ddr_writer.sv
// Directed bench for adc_ddr_writer; expectations follow ACQ_HEADER_EN the same way the RTL does.
// Transfers and Acq_Done pulses are logged on the falling edge and compared against a word list.
module tb_adc_ddr_writer;

  localparam int DEPTH = 8;
`ifdef ACQ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [15:0] ADC_Data;
  logic        ADC_Conv_Done;
  logic        DDR_WR_Start;
  logic [31:0] Base_Addr;
  logic [15:0] Acq_Length;
  logic        Busy, Acq_Done, Overflow;

  adc_ddr_writer_if #(.ADDR_W(32)) wr_if ();

  adc_ddr_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .ADC_Data      (ADC_Data),
    .ADC_Conv_Done (ADC_Conv_Done),
    .DDR_WR_Start  (DDR_WR_Start),
    .Base_Addr     (Base_Addr),
    .Acq_Length    (Acq_Length),
    .wr            (wr_if.master),
    .Busy          (Busy),
    .Acq_Done      (Acq_Done),
    .Overflow      (Overflow)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [63:0] log_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] nxt_addr;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr, stall_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfer log, Acq_Done counter and stall-stability checker
  always @(negedge Clk) begin
    if (!Rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_req",  wr_if.Wr_Req,  1);
        check("stall_addr", wr_if.Wr_Addr, stall_addr);
        check("stall_data", wr_if.Wr_Data, stall_data);
      end
      stall_prev = wr_if.Wr_Req && !wr_if.Wr_Ack;
      stall_addr = wr_if.Wr_Addr;
      stall_data = wr_if.Wr_Data;
      if (wr_if.Wr_Req && wr_if.Wr_Ack) log_q.push_back({wr_if.Wr_Addr, wr_if.Wr_Data});
      if (Acq_Done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic exp_begin(input logic [31:0] base, input logic [15:0] len);
    nxt_addr = base;
    if (HDR == 1) begin
      exp_q.push_back({nxt_addr, 16'hA5A5, len});
      nxt_addr = nxt_addr + 32'd4;
    end
  endtask

  task automatic exp_word(input logic [31:0] data);
    exp_q.push_back({nxt_addr, data});
    nxt_addr = nxt_addr + 32'd4;
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] len);
    DDR_WR_Start = 1'b1;
    Base_Addr    = base;
    Acq_Length   = len;
    tick();
    DDR_WR_Start = 1'b0;
    Base_Addr    = 32'hDEAD_BEE0;
    Acq_Length   = 16'd7;
    exp_begin(base, len);
  endtask

  task automatic send_sample(input logic [15:0] d);
    ADC_Data      = d;
    ADC_Conv_Done = 1'b1;
    tick();
    ADC_Conv_Done = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_pulses"}, done_cnt, d0 + 1);
    tick();
    check({tag, "_done_low"}, Acq_Done, 0);
    check({tag, "_busy_low"}, Busy, 0);
  endtask

  task automatic cmp_log(input string tag);
    check({tag, "_n_xfers"}, log_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < log_q.size()) check({tag, "_xfer"}, log_q[i], exp_q[i]);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0;
    Rst_n         = 1'b0;
    ADC_Data      = '0;
    ADC_Conv_Done = 1'b0;
    DDR_WR_Start  = 1'b0;
    Base_Addr     = '0;
    Acq_Length    = '0;
    wr_if.Wr_Ack  = 1'b1;

    // Reset values
    #12;
    check("rst_wr_req",   wr_if.Wr_Req,  0);
    check("rst_wr_addr",  wr_if.Wr_Addr, 0);
    check("rst_wr_data",  wr_if.Wr_Data, 0);
    check("rst_busy",     Busy,          0);
    check("rst_acq_done", Acq_Done,      0);
    check("rst_overflow", Overflow,      0);
    #1 Rst_n = 1'b1;
    tick();

    // Length 4, Wr_Ack high: two words, one-cycle request latency
    d0 = done_cnt;
    start(32'h1000_0000, 16'd4);
    check("t1_busy", Busy, 1);
    send_sample(16'h0001);
    ADC_Data      = 16'h0002;
    ADC_Conv_Done = 1'b1;
    @(negedge Clk);
    check("t1_req_before_push", wr_if.Wr_Req, 0);
    tick();
    ADC_Conv_Done = 1'b0;
    check("t1_req_after_push", wr_if.Wr_Req,  1);
    check("t1_first_data",     wr_if.Wr_Data, 32'h0002_0001);
    check("t1_first_addr",     wr_if.Wr_Addr, 32'h1000_0000 + 32'(4 * HDR));
    tick();
    send_sample(16'h0003);
    send_sample(16'h0004);
    exp_word(32'h0002_0001);
    exp_word(32'h0004_0003);
    wait_done("t1", d0);
    cmp_log("t1");

    // Odd length 3 with a second start pulse mid-capture
    d0 = done_cnt;
    start(32'h0000_0100, 16'd3);
    send_sample(16'hAAAA);
    DDR_WR_Start = 1'b1;
    Base_Addr    = 32'h0000_9000;
    Acq_Length   = 16'd9;
    tick();
    DDR_WR_Start = 1'b0;
    send_sample(16'hBBBB);
    send_sample(16'hCCCC);
    exp_word(32'hBBBB_AAAA);
    exp_word(32'h0000_CCCC);
    wait_done("t2", d0);
    cmp_log("t2");

    // Overflow: Wr_Ack held low, 20 samples into an 8-deep buffer
    wr_if.Wr_Ack = 1'b0;
    d0 = done_cnt;
    start(32'h0000_2000, 16'd20);
    for (int i = 0; i < 20; i++) send_sample(16'(i + 1));
    repeat (4) tick();
    check("t3_req",      wr_if.Wr_Req,  1);
    check("t3_overflow", Overflow,      1);
    check("t3_busy",     Busy,          1);
    check("t3_no_done",  done_cnt,      d0);
    check("t3_hold_addr", wr_if.Wr_Addr, 32'h0000_2000);
    for (int k = 0; k < DEPTH - HDR; k++) exp_word({16'(2 * k + 2), 16'(2 * k + 1)});
    wr_if.Wr_Ack = 1'b1;
    wait_done("t3", d0);
    cmp_log("t3");
    check("t3_overflow_sticky", Overflow, 1);

    // Wr_Ack toggling during drain
    wr_if.Wr_Ack = 1'b0;
    d0 = done_cnt;
    start(32'h0000_3000, 16'd6);
    check("t4_overflow_cleared", Overflow, 0);
    for (int i = 0; i < 6; i++) send_sample(16'hC000 + 16'(i));
    for (int i = 0; i < 12; i++) begin
      wr_if.Wr_Ack = (i % 2 == 0);
      tick();
    end
    wr_if.Wr_Ack = 1'b1;
    exp_word(32'hC001_C000);
    exp_word(32'hC003_C002);
    exp_word(32'hC005_C004);
    wait_done("t4", d0);
    cmp_log("t4");

    // Reset in the middle of a capture, then a clean length-2 capture
    start(32'h0000_4000, 16'd8);
    send_sample(16'h0A01);
    send_sample(16'h0A02);
    send_sample(16'h0A03);
    #2 Rst_n = 1'b0;
    #1;
    check("t5_rst_req",      wr_if.Wr_Req,  0);
    check("t5_rst_addr",     wr_if.Wr_Addr, 0);
    check("t5_rst_data",     wr_if.Wr_Data, 0);
    check("t5_rst_busy",     Busy,          0);
    check("t5_rst_done",     Acq_Done,      0);
    check("t5_rst_overflow", Overflow,      0);
    tick();
    tick();
    Rst_n = 1'b1;
    send_sample(16'h0A04);
    repeat (3) tick();
    check("t5_idle_busy", Busy,         0);
    check("t5_idle_req",  wr_if.Wr_Req, 0);
    log_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    start(32'h0000_0040, 16'd2);
    send_sample(16'h1234);
    send_sample(16'h5678);
    exp_word(32'h5678_1234);
    wait_done("t5", d0);
    cmp_log("t5");

    // Zero length: header only (if enabled), then Acq_Done
    d0 = done_cnt;
    start(32'h0000_0500, 16'd0);
    wait_done("t6", d0);
    cmp_log("t6");

    // Address wrap at the top of the address space
    d0 = done_cnt;
    start(32'hFFFF_FFFC, 16'd4);
    send_sample(16'h0011);
    send_sample(16'h0022);
    send_sample(16'h0033);
    send_sample(16'h0044);
    exp_word(32'h0022_0011);
    exp_word(32'h0044_0033);
    wait_done("t7", d0);
    cmp_log("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
